cail_param_loader: RTL

Sequences the EEPROM controller to fetch and store the ADC calibration constants (offset `cail_sub`, gain `cail_mult`) that drive the calibration datapath. After reset it reads a 9-byte record and verifies its checksum. It then presents the two 32-bit words, or fallback defaults if the record is bad, on stable outputs with a valid flag. The sample path holds its calibration enable until that flag is high. On host request it also writes a new record back to EEPROM, and it can reload the record on command.

---
 rtl/cail_param_loader_if.sv | 31 +++
 rtl/cail_param_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cail_param_loader_if.sv
// EEPROM byte-access bus between the calibration loader and the
// EEPROM controller: level request, one-cycle done/err response.
interface cail_param_loader_if;
   logic        ee_rd_req_o;
   logic        ee_wr_req_o;
   logic [15:0] ee_addr_o;
   logic [7:0]  ee_wdata_o;
   logic [7:0]  ee_rdata_i;
   logic        ee_done_i;
   logic        ee_err_i;

   modport master (
      output ee_rd_req_o,
      output ee_wr_req_o,
      output ee_addr_o,
      output ee_wdata_o,
      input  ee_rdata_i,
      input  ee_done_i,
      input  ee_err_i
   );

   modport slave (
      input  ee_rd_req_o,
      input  ee_wr_req_o,
      input  ee_addr_o,
      input  ee_wdata_o,
      output ee_rdata_i,
      output ee_done_i,
      output ee_err_i
   );
endinterface

// File: rtl/cail_param_loader.sv
// Loads/saves the 9-byte ADC calibration record (offset, gain,
// checksum) over the EEPROM byte bus and presents the active words.
module cail_param_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h0000,
   parameter logic [31:0] DEF_SUB   = 32'd0,
   parameter logic [31:0] DEF_MULT  = 32'h0001_0000,
   parameter int unsigned RETRY     = 2,
   parameter logic [23:0] TIMEOUT   = 24'd5_000_000
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       reload_i,
   input  logic                       save_i,
   input  logic [31:0]                sub_i,
   input  logic [31:0]                mult_i,
   cail_param_loader_if.master        ee,
   output logic [31:0]                cail_sub_o,
   output logic [31:0]                cail_mult_o,
   output logic                       param_valid_o,
   output logic                       param_src_o,
   output logic                       busy_o,
   output logic                       err_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_REQ,
      S_LOAD_WAIT,
      S_CHECK,
      S_RETRY,
      S_SAVE_REQ,
      S_SAVE_WAIT,
      S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  att_q, att_d;
   logic [23:0] tcnt_q, tcnt_d;
   logic [63:0] data_q, data_d;
   logic [7:0]  sum_q, sum_d;
   logic [7:0]  chk_q, chk_d;
   logic        rd_req_q, rd_req_d;
   logic        wr_req_q, wr_req_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [31:0] sub_q, sub_d;
   logic [31:0] mult_q, mult_d;
   logic        valid_q, valid_d;
   logic        src_q, src_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;

   logic        tmo;
   logic [2:0]  bsel;
   logic [7:0]  sel_byte;
   logic [15:0] byte_addr;

   function automatic logic [7:0] byte_sum(input logic [63:0] v);
      logic [7:0] s;
      s = 8'd0;
      for (int i = 0; i < 8; i++) s = s + v[i*8 +: 8];
      return s;
   endfunction

   assign tmo       = (tcnt_q == TIMEOUT - 24'd1);
   assign bsel      = 3'd7 - idx_q[2:0];
   assign byte_addr = BASE_ADDR + {12'd0, idx_q};
   // byte 8 of a save is the checksum of the captured words
   assign sel_byte  = (idx_q == 4'd8) ? ~sum_q
                                      : data_q[{bsel, 3'b000} +: 8];

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      att_d    = att_q;
      tcnt_d   = tcnt_q;
      data_d   = data_q;
      sum_d    = sum_q;
      chk_d    = chk_q;
      rd_req_d = rd_req_q;
      wr_req_d = wr_req_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      sub_d    = sub_q;
      mult_d   = mult_q;
      valid_d  = valid_q;
      src_d    = src_q;
      err_d    = err_q;
      unique case (state_q)
         S_IDLE: begin
            idx_d   = 4'd0;
            att_d   = 8'd0;
            state_d = S_LOAD_REQ;
         end
         S_LOAD_REQ: begin
            rd_req_d = 1'b1;
            addr_d   = byte_addr;
            tcnt_d   = 24'd0;
            if (idx_q == 4'd0) sum_d = 8'd0;
            state_d  = S_LOAD_WAIT;
         end
         S_LOAD_WAIT: begin
            tcnt_d = tcnt_q + 24'd1;
            if (ee.ee_done_i) begin
               rd_req_d = 1'b0;
               if (idx_q == 4'd8) begin
                  chk_d   = ee.ee_rdata_i;
                  state_d = S_CHECK;
               end else begin
                  data_d  = {data_q[55:0], ee.ee_rdata_i};
                  sum_d   = sum_q + ee.ee_rdata_i;
                  idx_d   = idx_q + 4'd1;
                  state_d = S_LOAD_REQ;
               end
            end else if (ee.ee_err_i || tmo) begin
               rd_req_d = 1'b0;
               state_d  = S_RETRY;
            end
         end
         S_CHECK: begin
            if (~sum_q == chk_q) begin
               sub_d   = data_q[63:32];
               mult_d  = data_q[31:0];
               src_d   = 1'b1;
               err_d   = 1'b0;
               valid_d = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_RETRY;
            end
         end
         S_RETRY: begin
            if (32'(att_q) < RETRY) begin
               att_d   = att_q + 8'd1;
               idx_d   = 4'd0;
               state_d = S_LOAD_REQ;
            end else begin
               sub_d   = DEF_SUB;
               mult_d  = DEF_MULT;
               src_d   = 1'b0;
               err_d   = 1'b1;
               valid_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_SAVE_REQ: begin
            wr_req_d = 1'b1;
            addr_d   = byte_addr;
            wdata_d  = sel_byte;
            tcnt_d   = 24'd0;
            state_d  = S_SAVE_WAIT;
         end
         S_SAVE_WAIT: begin
            tcnt_d = tcnt_q + 24'd1;
            if (ee.ee_done_i) begin
               wr_req_d = 1'b0;
               if (idx_q == 4'd8) begin
                  sub_d   = data_q[63:32];
                  mult_d  = data_q[31:0];
                  src_d   = 1'b1;
                  err_d   = 1'b0;
                  valid_d = 1'b1;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = S_SAVE_REQ;
               end
            end else if (ee.ee_err_i || tmo) begin
               wr_req_d = 1'b0;
               err_d    = 1'b1;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (save_i) begin
               data_d  = {sub_i, mult_i};
               sum_d   = byte_sum({sub_i, mult_i});
               idx_d   = 4'd0;
               state_d = S_SAVE_REQ;
            end else if (reload_i) begin
               idx_d   = 4'd0;
               att_d   = 8'd0;
               state_d = S_LOAD_REQ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= 4'd0;
         att_q    <= 8'd0;
         tcnt_q   <= 24'd0;
         data_q   <= 64'd0;
         sum_q    <= 8'd0;
         chk_q    <= 8'd0;
         rd_req_q <= 1'b0;
         wr_req_q <= 1'b0;
         addr_q   <= BASE_ADDR;
         wdata_q  <= 8'd0;
         sub_q    <= DEF_SUB;
         mult_q   <= DEF_MULT;
         valid_q  <= 1'b0;
         src_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         att_q    <= att_d;
         tcnt_q   <= tcnt_d;
         data_q   <= data_d;
         sum_q    <= sum_d;
         chk_q    <= chk_d;
         rd_req_q <= rd_req_d;
         wr_req_q <= wr_req_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         sub_q    <= sub_d;
         mult_q   <= mult_d;
         valid_q  <= valid_d;
         src_q    <= src_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign ee.ee_rd_req_o = rd_req_q;
   assign ee.ee_wr_req_o = wr_req_q;
   assign ee.ee_addr_o   = addr_q;
   assign ee.ee_wdata_o  = wdata_q;
   assign cail_sub_o     = sub_q;
   assign cail_mult_o    = mult_q;
   assign param_valid_o  = valid_q;
   assign param_src_o    = src_q;
   assign busy_o         = busy_q;
   assign err_o          = err_q;

endmodule
